spi_cmd_decoder: RTL
====================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535, SHALL set the max clk cycles allowed between bytes of one command.
REQ-002 clk  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 byte_in  input  8  received SPI byte from spi_slave byte_out, synchronous to clk.
REQ-005 byte_valid  input  1  one-cycle pulse qualifying byte_in.
REQ-006 spi_ss  input  1  chip select, active-low, synchronous to clk.
REQ-007 cmd_valid  output  1  command available; held until accepted.
REQ-008 cmd_ready  input  1  consumer accepts command when cmd_valid && cmd_ready.
REQ-009 cmd_opcode  output  8  opcode of the held command.
REQ-010 cmd_payload  output  24  payload; first payload byte in [7:0], next in [15:8], then [23:16]; unused bytes zero.
REQ-011 err_valid  output  1  one-cycle error pulse.
REQ-012 err_code  output  2  00 overrun, 01 abort, 10 timeout, 11 checksum; valid when err_valid is high.
REQ-013 busy  output  1  high while a command is partially received.

Function
REQ-014 Payload length SHALL be opcode[7:6] (0..3 bytes).
REQ-015 States SHALL be IDLE, PAYLOAD and CHECK (CHECK only with CMD_CHECKSUM_EN).
REQ-016 IDLE: a byte_valid with spi_ss low latches the opcode; length 0 -> command completes that cycle, else -> PAYLOAD.
REQ-017 PAYLOAD: each byte_valid stores the next payload byte; after the last byte -> IDLE with command complete (or -> CHECK).
REQ-018 On completion, cmd_valid SHALL rise the cycle after the final byte_valid, with opcode/payload stable until handshake.
REQ-019 cmd_valid SHALL clear the cycle after cmd_valid && cmd_ready.
REQ-020 If a command completes while cmd_valid is high and cmd_ready is low, the new command SHALL be dropped and err_valid/err_code=00 pulsed; the held command is unchanged.
REQ-021 Completion in the same cycle as an accepting handshake SHALL load the new command with no error.
REQ-022 spi_ss high while busy SHALL pulse err 01 and return to IDLE; byte_valid while spi_ss high SHALL be ignored.
REQ-023 Timeout counter SHALL reset on each accepted byte and count while busy; reaching TIMEOUT_CYCLES SHALL pulse err 10 and return to IDLE.
REQ-024 Abort SHALL take priority over timeout when both occur in one cycle.
REQ-025 busy SHALL be high exactly in states PAYLOAD and CHECK.

Reset
REQ-026 rst_n low SHALL force IDLE, cmd_valid=0, cmd_opcode=0, cmd_payload=0, err_valid=0, err_code=0, busy=0, timeout counter=0, immediately.
REQ-027 Reset mid-command SHALL discard the partial command without error pulse.

Configuration
REQ-028 Macro CMD_CHECKSUM_EN defined: after the payload one extra byte SHALL be received in CHECK; command completes only if it equals XOR of opcode and all payload bytes, else err 11 and drop.
REQ-029 Macro undefined: no CHECK state, no checksum byte, err_code 11 never produced.

Structure
REQ-030 Shared package spi_pkg SHALL hold the state encoding, err_code constants and the opcode length-field position.
REQ-031 The timeout counter SHALL be a sub-module spi_timeout_counter (clear, enable, expired).

Verification
REQ-032 Bytes 0x05 (len 0), cmd_ready=1 -> cmd_valid one cycle, opcode 0x05, payload 0x000000.
REQ-033 Bytes 0xC1,0x11,0x22,0x33 -> opcode 0xC1, payload 0x332211, busy high between first and last byte.
REQ-034 Bytes 0x81,0xAA then spi_ss high -> err 01, no cmd_valid, busy 0.
REQ-035 TIMEOUT_CYCLES=16, byte 0x41 then idle 16 cycles -> err 10, IDLE.
REQ-036 Two 0x05 commands with cmd_ready=0 -> first held, second dropped with err 00.
REQ-037 CMD_CHECKSUM_EN: 0x41,0x10,0x51 -> command accepted; 0x41,0x10,0x50 -> err 11, no cmd_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command decoder.
// CMD_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1
`ifdef CMD_CHECKSUM_EN
    ,
    ST_CHECK   = 2'd2
`endif
  } state_t;

  localparam logic [1:0] ERR_OVERRUN  = 2'b00;
  localparam logic [1:0] ERR_ABORT    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 6;

  function automatic logic [1:0] opc_len(input logic [7:0] op);
    return op[LEN_MSB:LEN_LSB];
  endfunction

  // Payload byte n lands in bits [8n+7:8n].
  function automatic logic [23:0] insert_byte(input logic [23:0] pay,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
    logic [23:0] r;
    r = pay;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      default: r[23:16] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_timeout_counter.sv
// Inter-byte watchdog: down-counter loaded on clear, flags expiry at terminal count.
module spi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= CW'(TIMEOUT_CYCLES);
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // The TIMEOUT_CYCLES-th enabled cycle after a clear is the expiring one.
  assign expired = enable && !clear && (count == CW'(1));

endmodule

// File: rtl/spi_cmd_decoder.sv
// Assembles opcode + payload bytes from an SPI byte stream into held commands.
// Optional CMD_CHECKSUM_EN: trailing XOR checksum byte verified in CHECK.
//
// state   | meaning
// IDLE    | waiting for opcode byte
// PAYLOAD | collecting opcode[7:6] payload bytes
// CHECK   | waiting for checksum byte (CMD_CHECKSUM_EN only)
module spi_cmd_decoder
  import spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        spi_ss,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [23:0] cmd_payload,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        busy
);

  state_t      state;
  logic [7:0]  op_q;
  logic [23:0] pay_q;
  logic [1:0]  len_q;
  logic [1:0]  idx_q;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        byte_ok;
  logic        abort;
  logic        tmo;
  logic        last;
  logic        complete;
  logic [7:0]  comp_op;
  logic [23:0] comp_pay;

  spi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (byte_ok),
    .enable (state != ST_IDLE),
    .expired(tmo)
  );

  always_comb begin
    byte_ok  = byte_valid && !spi_ss;
    abort    = (state != ST_IDLE) && spi_ss;
    last     = ((idx_q + 2'd1) == len_q);
    complete = 1'b0;
    comp_op  = op_q;
    comp_pay = pay_q;
    case (state)
      ST_IDLE: begin
        comp_op  = byte_in;
        comp_pay = '0;
`ifndef CMD_CHECKSUM_EN
        complete = byte_ok && (opc_len(byte_in) == 2'd0);
`endif
      end
      ST_PAYLOAD: begin
        comp_pay = insert_byte(pay_q, idx_q, byte_in);
`ifndef CMD_CHECKSUM_EN
        complete = byte_ok && !abort && !tmo && last;
`endif
      end
`ifdef CMD_CHECKSUM_EN
      ST_CHECK: begin
        complete = byte_ok && !abort && !tmo && (byte_in == csum_q);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      pay_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
`ifdef CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_payload <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      // A completion while the consumer is stalled is dropped, not queued.
      if (complete) begin
        if (cmd_valid && !cmd_ready) begin
          err_valid <= 1'b1;
          err_code  <= ERR_OVERRUN;
        end else begin
          cmd_valid   <= 1'b1;
          cmd_opcode  <= comp_op;
          cmd_payload <= comp_pay;
        end
      end

      case (state)
        ST_IDLE: begin
          if (byte_ok) begin
            op_q  <= byte_in;
            pay_q <= '0;
            len_q <= opc_len(byte_in);
            idx_q <= '0;
`ifdef CMD_CHECKSUM_EN
            csum_q <= byte_in;
            if (opc_len(byte_in) == 2'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_PAYLOAD;
            end
            busy <= 1'b1;
`else
            if (opc_len(byte_in) != 2'd0) begin
              state <= ST_PAYLOAD;
              busy  <= 1'b1;
            end
`endif
          end
        end

        ST_PAYLOAD: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_ABORT;
          end else if (tmo) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else if (byte_ok) begin
            pay_q <= comp_pay;
            idx_q <= idx_q + 2'd1;
`ifdef CMD_CHECKSUM_EN
            csum_q <= csum_q ^ byte_in;
            if (last) state <= ST_CHECK;
`else
            if (last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
`endif
          end
        end

`ifdef CMD_CHECKSUM_EN
        ST_CHECK: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_ABORT;
          end else if (tmo) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else if (byte_ok) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (byte_in != csum_q) begin
              err_valid <= 1'b1;
              err_code  <= ERR_CHECKSUM;
            end
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
